// File: rtl/turf_scaler_snapshot_if.sv
// turf_scaler_snapshot_if: scaler mux address/data bus and host read port of the snapshot engine
interface turf_scaler_snapshot_if;
  logic [5:0]  scal_addr_o;
  logic [31:0] scal_dat_i;
  logic        rd_req_i;
  logic [5:0]  rd_addr_i;
  logic [31:0] rd_dat_o;
  logic        rd_ack_o;
  modport slave (
    output scal_addr_o, rd_dat_o, rd_ack_o,
    input  scal_dat_i, rd_req_i, rd_addr_i
  );
  modport master (
    input  scal_addr_o, rd_dat_o, rd_ack_o,
    output scal_dat_i, rd_req_i, rd_addr_i
  );
endinterface

// File: rtl/turf_scaler_snapshot.sv
// turf_scaler_snapshot: per-PPS sweep of the scaler mux into a double-buffered frame RAM with atomic commit; SCALER_SNAP_CKSUM_EN adds an XOR checksum word 36
module turf_scaler_snapshot #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_WORDS     = 36
) (
  input  logic                  clk33_i,
  input  logic                  rst_n_i,
  input  logic                  pps_i,
  input  logic                  lock_i,
  input  logic                  clr_overrun_i,
  turf_scaler_snapshot_if.slave bus,
  output logic [15:0]           seq_o,
  output logic                  valid_o,
  output logic                  overrun_o,
  output logic                  done_o
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SWEEP  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;
`ifdef SCALER_SNAP_CKSUM_EN
  localparam logic [5:0] RD_LIM = 6'(NUM_WORDS + 1);
`else
  localparam logic [5:0] RD_LIM = 6'(NUM_WORDS);
`endif
  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [5:0]  r_addr;
  logic        r_bank;
  logic        r_pend;
  logic        r_ack;
  logic        r_valid;
  logic        r_ovr;
  logic        r_done;
  logic [15:0] r_seq;
  logic [31:0] r_rd_dat;
  logic [31:0] r_mem [0:127];
  logic [5:0]  w_next;
  logic [5:0]  w_map_next;
  logic        w_settled;
  logic        w_last;
  logic        w_commit;
  logic        w_swap;
  // the shadow bank is always the inactive one; the aux words skip 0x22/0x23
  assign w_next     = r_cnt + 6'd1;
  assign w_map_next = w_next < 6'd34 ? w_next : w_next + 6'd2;
  assign w_settled  = r_state == S_SETTLE && r_cnt == 6'(SETTLE_CYCLES - 1);
  assign w_last     = r_state == S_SWEEP && r_cnt == 6'(NUM_WORDS - 1);
  assign w_commit   = r_state == S_COMMIT;
  assign w_swap     = (w_commit || r_pend) && !lock_i;
  assign bus.scal_addr_o = r_addr;
  assign bus.rd_dat_o    = r_rd_dat;
  assign bus.rd_ack_o    = r_ack;
  assign seq_o     = r_seq;
  assign valid_o   = r_valid;
  assign overrun_o = r_ovr;
  assign done_o    = r_done;
  // sequencer, bank swap bookkeeping, status flags and registered host reads
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_bank   <= 1'b0;
      r_pend   <= 1'b0;
      r_ack    <= 1'b0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
      r_done   <= 1'b0;
      r_seq    <= '0;
      r_rd_dat <= '0;
    end else begin
      r_done <= w_last;
      r_ovr  <= (pps_i && r_state != S_IDLE) || (r_ovr && !clr_overrun_i);
      r_pend <= (w_commit || r_pend) && lock_i;
      r_ack  <= bus.rd_req_i;
      if (bus.rd_req_i)
        r_rd_dat <= bus.rd_addr_i < RD_LIM ? r_mem[{r_bank, bus.rd_addr_i}] : 32'h0;
      if (w_swap) begin
        r_bank  <= ~r_bank;
        r_seq   <= r_seq + 16'd1;
        r_valid <= 1'b1;
      end
      if (r_state == S_IDLE && pps_i) begin
        r_state <= S_SETTLE;
        r_cnt   <= '0;
      end else if (r_state == S_SETTLE) begin
        r_cnt <= w_settled ? 6'd0 : w_next;
        if (w_settled) begin
          r_state <= S_SWEEP;
          r_addr  <= '0;
        end
      end else if (r_state == S_SWEEP) begin
        r_cnt   <= w_next;
        r_addr  <= w_last ? 6'd0 : w_map_next;
        r_state <= w_last ? S_COMMIT : S_SWEEP;
      end else if (w_commit) begin
        r_state <= S_IDLE;
      end
    end
  end
`ifdef SCALER_SNAP_CKSUM_EN
  logic [31:0] r_csum;
  // running XOR of the words captured in the current sweep
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_csum <= '0;
    else
      r_csum <= w_settled ? 32'h0 : r_state == S_SWEEP ? r_csum ^ bus.scal_dat_i : r_csum;
  end
`endif
  // frame RAM writes: sweep words into the shadow bank, checksum lands in word 36 at commit
  always_ff @(posedge clk33_i) begin
    if (r_state == S_SWEEP)
      r_mem[{~r_bank, r_cnt}] <= bus.scal_dat_i;
`ifdef SCALER_SNAP_CKSUM_EN
    if (w_commit)
      r_mem[{~r_bank, 6'd36}] <= r_csum;
`endif
  end
endmodule

// File: tb/tb_turf_scaler_snapshot.sv
// tb_turf_scaler_snapshot: randomized self-checking bench against a frame-level reference model
module tb_turf_scaler_snapshot;
  localparam int S = 2;
`ifdef SCALER_SNAP_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, pps = 1'b0, lock = 1'b0, clr = 1'b0;
  logic [15:0] seq;
  logic valid, ovr, done;
  logic rnd_mode = 1'b0;
  logic [31:0] tab [64];
  logic [31:0] exp_act [37];
  logic [31:0] pend_frame [37];
  logic [15:0] exp_seq = '0;
  logic exp_valid = 1'b0;
  logic [5:0] addr_log [64];
  int n_checks = 0, n_errors = 0;
  int aux_addr [4] = '{32, 33, 36, 37};

  turf_scaler_snapshot_if bus();

  turf_scaler_snapshot #(.SETTLE_CYCLES(S)) dut (
    .clk33_i(clk), .rst_n_i(rst_n), .pps_i(pps), .lock_i(lock), .clr_overrun_i(clr),
    .bus(bus), .seq_o(seq), .valid_o(valid), .overrun_o(ovr), .done_o(done)
  );

  assign bus.scal_dat_i = rnd_mode ? tab[bus.scal_addr_o] : {26'h0, bus.scal_addr_o};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int idx_addr(input int k);
    return k < 32 ? k : aux_addr[k-32];
  endfunction

  function automatic logic [31:0] exp_word(input int a);
    return a <= 36 ? exp_act[a] : 32'h0;
  endfunction

  task automatic fill_tab();
    foreach (tab[i]) tab[i] = $urandom;
  endtask

  task automatic capture();
    logic [31:0] x;
    x = 32'h0;
    for (int k = 0; k < 36; k++) begin
      pend_frame[k] = rnd_mode ? tab[idx_addr(k)] : 32'(idx_addr(k));
      x ^= pend_frame[k];
    end
    pend_frame[36] = CK ? x : 32'h0;
  endtask

  task automatic apply_swap();
    exp_act = pend_frame;
    exp_seq++;
    exp_valid = 1'b1;
  endtask

  task automatic pulse_pps();
    pps = 1'b1;
    tick();
    pps = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (n < 64) addr_log[n] = bus.scal_addr_o;
      tick();
      n++;
    end
    if (n >= 200) check("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) cnt++;
    end
  endtask

  task automatic frame();
    int n;
    pulse_pps();
    wait_done(n);
    check("done_latency", n, S + 36);
    for (int k = 0; k < 36; k++)
      check($sformatf("sweep_addr[%0d]", k), 32'(addr_log[S+k]), idx_addr(k));
    capture();
    tick();
    check("done_pulse", 32'(done), 0);
    if (!lock) apply_swap();
    check("seq", 32'(seq), 32'(exp_seq));
    check("valid", 32'(valid), 32'(exp_valid));
  endtask

  task automatic rd(input int a);
    bus.rd_req_i = 1'b1;
    bus.rd_addr_i = 6'(a);
    tick();
    bus.rd_req_i = 1'b0;
    check("rd_ack", 32'(bus.rd_ack_o), 1);
    check($sformatf("rd[%0d]", a), bus.rd_dat_o, exp_word(a));
  endtask

  task automatic check_reset_outputs();
    check("rst_addr", 32'(bus.scal_addr_o), 0);
    check("rst_rd_dat", bus.rd_dat_o, 0);
    check("rst_rd_ack", 32'(bus.rd_ack_o), 0);
    check("rst_seq", 32'(seq), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_overrun", 32'(ovr), 0);
    check("rst_done", 32'(done), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, cnt, k;
    bus.rd_req_i = 1'b0;
    bus.rd_addr_i = '0;
    fill_tab();
    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    rnd_mode = 1'b0;
    frame();
    for (int a = 0; a <= 37; a++) rd(a);
    rd(63);
    rd(5);
    tick();
    check("ack_single", 32'(bus.rd_ack_o), 0);
    check("rd_hold", bus.rd_dat_o, exp_word(5));
    bus.rd_req_i = 1'b1;
    bus.rd_addr_i = 6'd3;
    tick();
    bus.rd_addr_i = 6'd33;
    check("b2b_ack0", 32'(bus.rd_ack_o), 1);
    check("b2b_dat0", bus.rd_dat_o, exp_word(3));
    tick();
    bus.rd_req_i = 1'b0;
    check("b2b_ack1", 32'(bus.rd_ack_o), 1);
    check("b2b_dat1", bus.rd_dat_o, exp_word(33));

    rnd_mode = 1'b1;
    fill_tab();
    pulse_pps();
    repeat (9) tick();
    pulse_pps();
    check("ovr_set", 32'(ovr), 1);
    wait_done(n);
    check("ovr_done_latency", n, S + 36 - 10);
    capture();
    tick();
    apply_swap();
    check("ovr_seq", 32'(seq), 32'(exp_seq));
    count_done(60, cnt);
    check("ovr_extra_done", cnt, 0);
    check("ovr_sticky", 32'(ovr), 1);
    pulse_pps();
    pps = 1'b1;
    clr = 1'b1;
    tick();
    pps = 1'b0;
    clr = 1'b0;
    check("ovr_set_wins", 32'(ovr), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovr_clear", 32'(ovr), 0);
    wait_done(n);
    capture();
    tick();
    apply_swap();
    check("ovr2_seq", 32'(seq), 32'(exp_seq));
    rd(34);

    fill_tab();
    frame();
    lock = 1'b1;
    fill_tab();
    frame();
    for (int i = 0; i < 4; i++) rd($urandom_range(0, 36));
    fill_tab();
    frame();
    for (int i = 0; i < 4; i++) rd($urandom_range(0, 36));
    k = $urandom_range(0, 35);
    lock = 1'b0;
    bus.rd_req_i = 1'b1;
    bus.rd_addr_i = 6'(k);
    tick();
    bus.rd_req_i = 1'b0;
    check("collide_old", bus.rd_dat_o, exp_word(k));
    apply_swap();
    check("unlock_seq", 32'(seq), 32'(exp_seq));
    rd(k);
    rd(36);
    count_done(5, cnt);
    check("unlock_single_swap", 32'(seq), 32'(exp_seq));

    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(0, 20)) tick();
      rnd_mode = 1'($urandom_range(0, 1));
      fill_tab();
      frame();
      for (int i = 0; i < 6; i++) rd($urandom_range(0, 63));
      rd(36);
    end

    rnd_mode = 1'b1;
    fill_tab();
    rd(7);
    pulse_pps();
    repeat (5) tick();
    pulse_pps();
    repeat (S + 20 - 6) tick();
    check("mid_sweep_addr", 32'(bus.scal_addr_o), 20);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) tick();
    rst_n = 1'b1;
    exp_seq = '0;
    exp_valid = 1'b0;
    count_done(60, cnt);
    check("abort_no_done", cnt, 0);
    check("abort_seq", 32'(seq), 0);
    fill_tab();
    frame();
    for (int a = 0; a <= 36; a++) rd(a);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
